// File: rtl/alu_arbiter_if.sv
// Signal bundle around the shared-ALU arbiter: two requesters, the response path and the ALU bus.
// slave is the arbiter's view; master is the environment (requesters plus the ALU itself).
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [6:0]  req0_fun7;
    logic [2:0]  req0_fun3;
    logic [31:0] req0_rs1;
    logic [31:0] req0_rs2;

    logic        req1_valid;
    logic        req1_ready;
    logic [6:0]  req1_fun7;
    logic [2:0]  req1_fun3;
    logic [31:0] req1_rs1;
    logic [31:0] req1_rs2;

    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_res;
    logic        rsp_zero;
    logic        rsp_neg;
    logic        rsp_err;
    logic        busy;

    logic        alu_start;
    logic [6:0]  alu_fun7;
    logic [2:0]  alu_fun3;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_res;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_done;

    modport slave (
        input  req0_valid, req0_fun7, req0_fun3, req0_rs1, req0_rs2,
        output req0_ready,
        input  req1_valid, req1_fun7, req1_fun3, req1_rs1, req1_rs2,
        output req1_ready,
        output rsp0_valid, rsp1_valid, rsp_res, rsp_zero, rsp_neg, rsp_err, busy,
        output alu_start, alu_fun7, alu_fun3, alu_rs1, alu_rs2,
        input  alu_res, alu_zero, alu_neg, alu_done
    );

    modport master (
        output req0_valid, req0_fun7, req0_fun3, req0_rs1, req0_rs2,
        input  req0_ready,
        output req1_valid, req1_fun7, req1_fun3, req1_rs1, req1_rs2,
        input  req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_res, rsp_zero, rsp_neg, rsp_err, busy,
        input  alu_start, alu_fun7, alu_fun3, alu_rs1, alu_rs2,
        output alu_res, alu_zero, alu_neg, alu_done
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (port 0) and the branch unit (port 1),
// with a start/done handshake, one-cycle response strobe and a watchdog on both handshake phases.
module alu_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    logic             r_cur_port;
    logic             r_alu_start;
    logic [6:0]       r_alu_fun7;
    logic [2:0]       r_alu_fun3;
    logic [31:0]      r_alu_rs1;
    logic [31:0]      r_alu_rs2;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [31:0]      r_rsp_res;
    logic             r_rsp_zero;
    logic             r_rsp_neg;
    logic             r_rsp_err;
    logic             r_busy;

    logic             w_rdy0;
    logic             w_rdy1;
    logic             w_accept;
    logic             w_grant;
    logic             w_cnt_last;
    logic [6:0]       w_fun7;
    logic [2:0]       w_fun3;
    logic [31:0]      w_rs1;
    logic [31:0]      w_rs2;

    assign w_accept   = w_rdy0 | w_rdy1;
    assign w_grant    = w_rdy1;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Ready decode: only in IDLE; on contention the port that did not win last time goes first.
    always_comb begin
        w_rdy0 = 1'b0;
        w_rdy1 = 1'b0;
        if (r_state == ST_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_rdy0 = r_last_grant;
                w_rdy1 = ~r_last_grant;
            end else begin
                w_rdy0 = bus.req0_valid;
                w_rdy1 = bus.req1_valid;
            end
        end else begin
            w_rdy0 = 1'b0;
            w_rdy1 = 1'b0;
        end
    end

    // Operand select for the granted port.
    always_comb begin
        if (w_grant) begin
            w_fun7 = bus.req1_fun7;
            w_fun3 = bus.req1_fun3;
            w_rs1  = bus.req1_rs1;
            w_rs2  = bus.req1_rs2;
        end else begin
            w_fun7 = bus.req0_fun7;
            w_fun3 = bus.req0_fun3;
            w_rs1  = bus.req0_rs1;
            w_rs2  = bus.req0_rs2;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; done has priority over the watchdog in START.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (bus.alu_done || w_cnt_last) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_RELEASE: begin
                if (!bus.alu_done || w_cnt_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered datapath: operand capture, watchdog counter, response capture and strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= CNT_ZERO;
            r_last_grant <= 1'b1;
            r_cur_port   <= 1'b0;
            r_alu_start  <= 1'b0;
            r_alu_fun7   <= 7'd0;
            r_alu_fun3   <= 3'd0;
            r_alu_rs1    <= 32'd0;
            r_alu_rs2    <= 32'd0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_res    <= 32'd0;
            r_rsp_zero   <= 1'b0;
            r_rsp_neg    <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_fun7   <= w_fun7;
                        r_alu_fun3   <= w_fun3;
                        r_alu_rs1    <= w_rs1;
                        r_alu_rs2    <= w_rs2;
                        r_cur_port   <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= CNT_ZERO;
                        r_alu_start  <= 1'b1;
                    end else begin
                        r_alu_start  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bus.alu_done) begin
                        r_rsp_res    <= bus.alu_res;
                        r_rsp_zero   <= bus.alu_zero;
                        r_rsp_neg    <= bus.alu_neg;
                        r_rsp_err    <= 1'b0;
                        r_alu_start  <= 1'b0;
                        r_cnt        <= CNT_ZERO;
                        r_rsp0_valid <= ~r_cur_port;
                        r_rsp1_valid <= r_cur_port;
                    end else if (w_cnt_last) begin
                        r_rsp_res    <= 32'd0;
                        r_rsp_zero   <= 1'b0;
                        r_rsp_neg    <= 1'b0;
                        r_rsp_err    <= 1'b1;
                        r_alu_start  <= 1'b0;
                        r_cnt        <= CNT_ZERO;
                        r_rsp0_valid <= ~r_cur_port;
                        r_rsp1_valid <= r_cur_port;
                    end else begin
                        r_cnt        <= r_cnt + CNT_ONE;
                    end
                end
                ST_RELEASE: begin
                    // The response is always strobed on RELEASE entry, so a timeout here only ends the wait.
                    if (bus.alu_done && !w_cnt_last) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end else begin
                        r_cnt <= CNT_ZERO;
                    end
                end
                default: begin
                    r_alu_start <= 1'b0;
                    r_cnt       <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_rdy0;
    assign bus.req1_ready = w_rdy1;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp_res    = r_rsp_res;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_neg    = r_rsp_neg;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.busy       = r_busy;
    assign bus.alu_start  = r_alu_start;
    assign bus.alu_fun7   = r_alu_fun7;
    assign bus.alu_fun3   = r_alu_fun3;
    assign bus.alu_rs1    = r_alu_rs1;
    assign bus.alu_rs2    = r_alu_rs2;
endmodule
